// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and line levels
// Holds the transmitter FSM state type, the serial line levels shared with the
// matching receiver, and a counter-width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - per-bit cycle counter producing a bit_end strobe
// Ports:
//   clk     - system clock
//   reset   - synchronous active-high reset, clears the count
//   load    - clears the count (start of a new frame)
//   enable  - count while a frame is in progress
//   bit_end - high on the last cycle of the current serial bit
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic bit_end
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // With CLKS_PER_BIT=1 the count sits at 0 and every enabled cycle is a bit end.
    assign bit_end = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || load) begin
            count <= '0;
        end else if (enable) begin
            count <= bit_end ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART-style parallel-to-serial transmitter
// Frame: start bit (0), DATA_WIDTH data bits LSB first, optional even parity,
// one stop bit (1). Every output is a flop.
// Ports:
//   clk       - system clock
//   reset     - synchronous active-high reset
//   tx_data   - word to send, sampled on the tx_valid && tx_ready edge
//   tx_valid  - tx_data is valid
//   tx_ready  - a word can be accepted this cycle
//   tx_serial - serial line, idles high
//   tx_busy   - a frame is in progress
//   tx_done   - one-cycle pulse after the stop bit completes
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_serial,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    uart_state_t           state, state_next;
    logic [DATA_WIDTH-1:0] shreg, shreg_next;
    logic [DATA_WIDTH-1:0] shifted;
    logic [BW-1:0]         bit_cnt, bit_cnt_next;
    logic                  parity_bit, parity_next;
    logic                  serial_next, ready_next, busy_next, done_next;
    logic                  load, bit_end;

    assign shifted = shreg >> 1;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .enable (state != IDLE),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            tx_serial  <= IDLE_LEVEL;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            bit_cnt    <= bit_cnt_next;
            parity_bit <= parity_next;
            tx_serial  <= serial_next;
            tx_ready   <= ready_next;
            tx_busy    <= busy_next;
            tx_done    <= done_next;
        end
    end

    // Next-state logic computes the value each output takes after the edge,
    // so the line changes on the same edge the FSM changes state.
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        parity_next  = parity_bit;
        serial_next  = tx_serial;
        ready_next   = tx_ready;
        busy_next    = tx_busy;
        done_next    = 1'b0;
        load         = 1'b0;

        case (state)
            IDLE: begin
                serial_next = IDLE_LEVEL;
                ready_next  = 1'b1;
                busy_next   = 1'b0;
                // tx_ready is registered, so this only fires in IDLE / the done cycle.
                if (tx_valid && tx_ready) begin
                    load         = 1'b1;
                    shreg_next   = tx_data;
                    parity_next  = ^tx_data;
                    bit_cnt_next = '0;
                    state_next   = START;
                    serial_next  = START_LEVEL;
                    ready_next   = 1'b0;
                    busy_next    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next  = DATA;
                    serial_next = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_next = shifted;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
                        if (PARITY_EN != 0) begin
                            state_next  = PARITY;
                            serial_next = parity_bit;
                        end else begin
                            state_next  = STOP;
                            serial_next = STOP_LEVEL;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                        serial_next  = shifted[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next  = STOP;
                    serial_next = STOP_LEVEL;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next  = IDLE;
                    serial_next = IDLE_LEVEL;
                    done_next   = 1'b1;
                    busy_next   = 1'b0;
                    ready_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic       ser0, rdy0, busy0, done0;
    logic       ser1, rdy1, busy1, done1;

    int         errors = 0;
    int         checks = 0;
    int         frames_seen = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
        .clk(clk), .reset(reset), .tx_data(data0), .tx_valid(valid0),
        .tx_ready(rdy0), .tx_serial(ser0), .tx_busy(busy0), .tx_done(done0)
    );

    uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
        .clk(clk), .reset(reset), .tx_data(data1), .tx_valid(valid1),
        .tx_ready(rdy1), .tx_serial(ser1), .tx_busy(busy1), .tx_done(done1)
    );

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
        int          nbits;
        bit          sel;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ser_of(input bit sel);
        return sel ? ser1 : ser0;
    endfunction
    function automatic logic rdy_of(input bit sel);
        return sel ? rdy1 : rdy0;
    endfunction
    function automatic logic busy_of(input bit sel);
        return sel ? busy1 : busy0;
    endfunction
    function automatic logic done_of(input bit sel);
        return sel ? done1 : done0;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            valid1 = v;
            data1  = d;
        end else begin
            valid0 = v;
            data0  = d;
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [10:0] fr, input int nbits,
                             input bit sel, input int glitch_at);
        @(negedge clk);
        chk("ready_idle", rdy_of(sel), 1);
        drive(sel, 1'b1, d);
        @(posedge clk);
        if (!sel) exp_q.push_back(d);
        #1 drive(sel, 1'b0, ~d);
        for (int c = 0; c < nbits * CPB; c++) begin
            @(negedge clk);
            if (glitch_at >= 0 && c == glitch_at) drive(sel, 1'b1, 8'h3C);
            else if (glitch_at >= 0 && c == glitch_at + 1) drive(sel, 1'b0, 8'h3C);
            chk("frame_bit", ser_of(sel), fr[c / CPB]);
            chk("no_early_done", done_of(sel), 0);
            if (c == 0) begin
                chk("busy_in_frame", busy_of(sel), 1);
                chk("ready_in_frame", rdy_of(sel), 0);
            end
        end
        @(negedge clk);
        chk("done_pulse", done_of(sel), 1);
        chk("ready_after", rdy_of(sel), 1);
        chk("idle_high", ser_of(sel), 1);
        chk("busy_after", busy_of(sel), 0);
        @(negedge clk);
        chk("done_one_cycle", done_of(sel), 0);
    endtask

    // Scoreboard monitor on dut0: rebuilds each word from mid-bit samples and
    // compares it with the word queued when its handshake was driven.
    initial begin : monitor
        logic       prev;
        logic [7:0] w;
        logic [7:0] e;
        bit         aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                prev = 1'b1;
            end else if (prev === 1'b1 && ser0 === 1'b0) begin
                aborted = 0;
                w = '0;
                for (int c = 1; c < 10 * CPB && !aborted; c++) begin
                    @(negedge clk);
                    if (reset !== 1'b0) aborted = 1;
                    else if (c % CPB == CPB / 2) begin
                        if (c / CPB >= 1 && c / CPB <= 8) w[c / CPB - 1] = ser0;
                        else if (c / CPB == 9) chk("mon_stop", ser0, 1);
                    end
                end
                if (!aborted) begin
                    frames_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mon_unexpected: got frame %0h expected none", w);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mon_word", w, e);
                    end
                end
                prev = ser0;
            end else begin
                prev = ser0;
            end
        end
    end

    initial begin
        int done_seen;

        vecs[0] = '{8'hA5, {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0};
        vecs[1] = '{8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b1};
        vecs[2] = '{8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1'b1};
        vecs[3] = '{8'h00, {1'b0, 1'b1, 8'h00, 1'b0}, 10, 1'b0};
        vecs[4] = '{8'h80, {1'b1, 1'b1, 8'h80, 1'b0}, 11, 1'b1};
        vecs[5] = '{8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}, 11, 1'b1};

        // Reset held with tx_valid high: nothing may be accepted.
        reset = 1'b1;
        drive(0, 1'b1, 8'hA5);
        drive(1, 1'b1, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_serial0", ser0, 1);
            chk("rst_ready0", rdy0, 1);
            chk("rst_busy0", busy0, 0);
            chk("rst_done0", done0, 0);
            chk("rst_serial1", ser1, 1);
            chk("rst_busy1", busy1, 0);
        end
        reset = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        @(negedge clk);
        chk("no_frame_after_rst0", busy0, 0);
        chk("no_frame_after_rst1", busy1, 0);
        chk("idle_line0", ser0, 1);

        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].data, vecs[i].frame, vecs[i].nbits, vecs[i].sel, -1);

        // Back-to-back: tx_valid held high across the tx_done cycle.
        @(negedge clk);
        drive(0, 1'b1, 8'h01);
        @(posedge clk);
        exp_q.push_back(8'h01);
        #1 data0 = 8'hFF;
        for (int c = 0; c < 10 * CPB; c++) begin
            @(negedge clk);
            chk("b2b_first_bit", ser0, ((11'b01_00000001_0) >> (c / CPB)) & 1);
        end
        @(negedge clk);
        chk("b2b_done", done0, 1);
        chk("b2b_ready", rdy0, 1);
        chk("b2b_gap_high", ser0, 1);
        @(posedge clk);
        exp_q.push_back(8'hFF);
        #1 drive(0, 1'b0, 8'h00);
        @(negedge clk);
        chk("b2b_next_start", ser0, 0);
        chk("b2b_busy", busy0, 1);
        for (int c = 1; c < 10 * CPB; c++) begin
            @(negedge clk);
            chk("b2b_second_bit", ser0, ((11'b01_11111111_0) >> (c / CPB)) & 1);
        end
        @(negedge clk);
        chk("b2b_done2", done0, 1);

        // A word offered mid-frame must be ignored.
        run_frame(8'hA5, {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0, 10);
        repeat (10) @(negedge clk);
        chk("ignored_word_idle", busy0, 0);

        // Reset during data bit 3 of 0xA5.
        @(negedge clk);
        drive(0, 1'b1, 8'hA5);
        @(posedge clk);
        exp_q.push_back(8'hA5);
        #1 drive(0, 1'b0, 8'hA5);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            chk("abort_frame_bit", ser0, ((11'b01_10100101_0) >> (c / CPB)) & 1);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_serial", ser0, 1);
        chk("abort_busy", busy0, 0);
        chk("abort_ready", rdy0, 1);
        chk("abort_done", done0, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        done_seen = 0;
        for (int c = 0; c < 44; c++) begin
            @(negedge clk);
            if (done0 !== 1'b0 || ser0 !== 1'b1) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        run_frame(8'h5A, {1'b0, 1'b1, 8'h5A, 1'b0}, 10, 1'b0, -1);

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("frames_seen", frames_seen, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
